// File: rtl/ring_route_pkg.sv
// Shared route indices, arbiter state type and the route conflict matrix
// for the ring route arbiter.
package ring_route_pkg;

  localparam int NUM_ROUTES = 8;

  localparam logic [2:0] ROUTE_A = 3'd0;
  localparam logic [2:0] ROUTE_B = 3'd1;
  localparam logic [2:0] ROUTE_C = 3'd2;
  localparam logic [2:0] ROUTE_D = 3'd3;
  localparam logic [2:0] ROUTE_E = 3'd4;
  localparam logic [2:0] ROUTE_F = 3'd5;
  localparam logic [2:0] ROUTE_G = 3'd6;
  localparam logic [2:0] ROUTE_H = 3'd7;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  // Row j lists the routes that may never be set together with route j.
  // Conflicting pairs: A-H, B-D, C-F, E-G. Leftmost element is row H.
  localparam logic [7:0][7:0] CONFLICT_MAP = {
    8'h01,  // H: A
    8'h10,  // G: E
    8'h04,  // F: C
    8'h40,  // E: G
    8'h02,  // D: B
    8'h20,  // C: F
    8'h08,  // B: D
    8'h80   // A: H
  };

  function automatic logic any_conflict(input logic [7:0] grant);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_ROUTES; j++) begin
      if (grant[j] && |(CONFLICT_MAP[j] & grant)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ring_route_arbiter_release_timer.sv
// Per-route busy flag: set on lock, held for RELEASE_CYCLES after the
// route is released, then cleared.
module route_release_timer #(
  parameter int RELEASE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  input  logic start_hold,
  output logic busy
);

  localparam logic [7:0] HOLD = 8'(RELEASE_CYCLES);

  logic [7:0] count;

  // A nonzero count means release hold; busy with zero count means locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (lock) begin
      busy <= 1'b1;
    end else if (start_hold) begin
      count <= HOLD;
    end else if (count != '0) begin
      count <= count - 8'd1;
      if (count == 8'd1) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_route_arbiter.sv
// Round-robin interlocking route arbiter with release hold and conflict alarm.
// Optional per-route starvation watchdog under macro ROUTE_WDOG_EN.
module ring_route_arbiter
  import ring_route_pkg::*;
#(
  parameter int RELEASE_CYCLES = 16,
  parameter int WDOG_CYCLES    = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  output logic [7:0] o_grant,
  output logic [7:0] o_busy,
  output logic       o_conflict_err,
`ifdef ROUTE_WDOG_EN
  output logic [7:0] o_starve,
`endif
  output arb_state_t o_state
);

  arb_state_t state;
  logic [2:0] ptr;
  logic [2:0] idx;
  logic [7:0] grant;
  logic       conflict_err;
  logic [7:0] lock_vec;
  logic [7:0] start_hold;
  logic       pick_ok;
  logic [2:0] pick;
  logic [2:0] cand;

  // Walk downward so the candidate closest to ptr is the one left standing.
  always_comb begin
    pick_ok = 1'b0;
    pick    = ptr;
    cand    = '0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (i_req[cand] && !o_busy[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    lock_vec = '0;
    if (state == LOCK) lock_vec[idx] = 1'b1;
    start_hold = grant & ~i_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= SCAN;
      ptr          <= '0;
      idx          <= '0;
      grant        <= '0;
      conflict_err <= 1'b0;
    end else begin
      grant <= grant & i_req;
      case (state)
        SCAN: begin
          if (pick_ok) begin
            idx   <= pick;
            state <= CHECK;
          end
        end
        // o_busy is registered, so a release this cycle cannot free a conflict yet.
        CHECK: begin
          if (!i_req[idx] || |(CONFLICT_MAP[idx] & o_busy)) begin
            ptr   <= idx + 3'd1;
            state <= SCAN;
          end else begin
            state <= LOCK;
          end
        end
        LOCK: begin
          grant[idx] <= 1'b1;
          ptr        <= idx + 3'd1;
          state      <= SCAN;
        end
        default: state <= SCAN;
      endcase
      if (any_conflict(grant)) conflict_err <= 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_ROUTES; r++) begin : g_route
    route_release_timer #(
      .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_timer (
      .clk       (i_clk),
      .rst       (i_rst),
      .lock      (lock_vec[r]),
      .start_hold(start_hold[r]),
      .busy      (o_busy[r])
    );
  end

`ifdef ROUTE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wait_cnt [NUM_ROUTES];
  logic [7:0]    starve;

  // Counts only while a request waits ungranted; cleared as the grant rises.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_ROUTES; r++) begin
      if (i_rst || !i_req[r] || grant[r] || lock_vec[r]) begin
        wait_cnt[r] <= '0;
        starve[r]   <= 1'b0;
      end else if (wait_cnt[r] != WW'(WDOG_CYCLES)) begin
        wait_cnt[r] <= wait_cnt[r] + WW'(1);
        if (wait_cnt[r] == WW'(WDOG_CYCLES - 1)) starve[r] <= 1'b1;
      end
    end
  end

  assign o_starve = starve;
`endif

  assign o_grant        = grant;
  assign o_conflict_err = conflict_err;
  assign o_state        = state;

endmodule

// File: tb/tb_ring_route_arbiter.sv
// Directed bench for ring_route_arbiter; expected grant order is queued as
// requests are driven and popped as each grant rises.
module tb_ring_route_arbiter;
  import ring_route_pkg::*;

  localparam int REL = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_req = '0;
  logic [7:0] o_grant;
  logic [7:0] o_busy;
  logic       o_conflict_err;
`ifdef ROUTE_WDOG_EN
  logic [7:0] o_starve;
`endif
  arb_state_t o_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];
  logic [7:0] prev_grant = '0;

  ring_route_arbiter #(
    .RELEASE_CYCLES(REL),
    .WDOG_CYCLES   (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req         (i_req),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_conflict_err(o_conflict_err),
`ifdef ROUTE_WDOG_EN
    .o_starve      (o_starve),
`endif
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = '0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic wait_grant(input int b, input int limit, output int edges);
    edges = 0;
    while (!o_grant[b] && edges < limit) begin
      tick();
      edges++;
    end
  endtask

  // Scoreboard monitor: every rising grant bit must match the queue head.
  always @(negedge i_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (o_grant[b] && !prev_grant[b]) begin
        if (exp_q.size() == 0) check("sb_unexpected_grant", 32'(b), 32'hFF);
        else check("sb_grant_order", 32'(b), 32'(exp_q.pop_front()));
      end
    end
    prev_grant = o_grant;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int fall;
    int rise;
    int hold;
    logic h_seen;

    // Reset state and first-grant latency.
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_err", 32'(o_conflict_err), 32'h0);
    check("rst_state", 32'(o_state), 32'(SCAN));
    i_req = 8'h01;
    exp_q.push_back(3'd0);
    tick(); check("a_lat_e1", 32'(o_grant), 32'h0);
    tick(); check("a_lat_e2", 32'(o_grant), 32'h0);
    tick(); check("a_lat_e3", 32'(o_grant), 32'h01);
    check("a_busy", 32'(o_busy), 32'h01);

    // H conflicts with A: blocked while A busy, granted after A's hold.
    i_req = 8'h81;
    exp_q.push_back(3'd7);
    h_seen = 1'b0;
    repeat (20) begin
      tick();
      if (o_grant[7]) h_seen = 1'b1;
    end
    check("h_blocked", 32'(h_seen), 32'h0);
    check("a_still_held", 32'(o_grant), 32'h01);
    i_req = 8'h80;
    fall = -1;
    rise = -1;
    for (int c = 1; c <= 40 && rise < 0; c++) begin
      tick();
      if (fall < 0 && !o_grant[0]) fall = c;
      if (o_grant[7]) rise = c;
    end
    check("h_release_latency_ok",
          32'(fall > 0 && rise > 0 && rise - fall >= REL + 2 && rise - fall <= REL + 10), 32'h1);
    check("h_busy_only", 32'(o_busy), 32'h80);

    // All routes requested: A,B,C,E win, the conflicting partners never do.
    do_reset();
    i_req = 8'hFF;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    repeat (60) tick();
    check("ff_grant", 32'(o_grant), 32'h17);
    check("ff_busy", 32'(o_busy), 32'h17);
    check("ff_no_conflict", 32'(o_conflict_err), 32'h0);

    // Reset while A,E locked and B in release hold.
    do_reset();
    i_req = 8'h13;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd4);
    repeat (25) tick();
    check("pre_rst_grant", 32'(o_grant), 32'h13);
    i_req = 8'h11;
    tick();
    check("pre_rst_grant11", 32'(o_grant), 32'h11);
    check("pre_rst_busy", 32'(o_busy), 32'h13);
    i_rst = 1'b1;
    tick();
    check("mid_rst_grant", 32'(o_grant), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    check("mid_rst_err", 32'(o_conflict_err), 32'h0);
    check("mid_rst_state", 32'(o_state), 32'(SCAN));
`ifdef ROUTE_WDOG_EN
    check("mid_rst_starve", 32'(o_starve), 32'h0);
`endif
    i_rst = 1'b0;
    i_req = '0;
    tick();
    check("post_rst_no_hold", 32'(o_busy), 32'h0);

    // B dropped then reraised during hold: hold runs its full length.
    do_reset();
    i_req = 8'h02;
    exp_q.push_back(3'd1);
    wait_grant(1, 10, e);
    check("b_first_lat", 32'(e), 32'd3);
    i_req = 8'h00;
    tick();
    check("b_released", 32'(o_grant), 32'h0);
    hold = 0;
    while (o_busy[1] && hold < 20) begin
      hold++;
      if (hold == 2) begin
        i_req = 8'h02;
        exp_q.push_back(3'd1);
      end
      tick();
    end
    check("b_hold_len", 32'(hold), 32'(REL));
    wait_grant(1, 10, e);
    check("b_regrant_lat", 32'(e), 32'd3);

`ifdef ROUTE_WDOG_EN
    // H starves behind A, flag clears on H's grant.
    do_reset();
    i_req = 8'h01;
    exp_q.push_back(3'd0);
    wait_grant(0, 10, e);
    check("wd_a_grant", 32'(o_grant), 32'h01);
    i_req = 8'h81;
    exp_q.push_back(3'd7);
    repeat (7) tick();
    check("wd_starve_7", 32'(o_starve), 32'h0);
    tick();
    check("wd_starve_8", 32'(o_starve), 32'h80);
    i_req = 8'h80;
    wait_grant(7, 40, e);
    check("wd_h_grant", 32'(o_grant[7]), 32'h1);
    check("wd_starve_clr", 32'(o_starve), 32'h0);
`endif

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
